// File: rtl/fetch_sequencer.sv
// IF-stage fetch sequencer: owns the fetch PC, keeps one instruction-memory request
// in flight, and presents fetched words to decode through a valid/stall slot.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        stall,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] pc_out
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DRAIN
    } fetchState_e;

    fetchState_e state_q;
    logic [31:0] fetchPc_q;
    logic        ifValid_q;
    logic [31:0] ifPc_q;
    logic [31:0] ifInstr_q;

    logic        reqAccepted;
    logic        slotConsumed;
    logic [31:0] redirectTarget;
    logic [31:0] fetchPcInc;

    // A request may only go out when the slot is empty or drains this cycle,
    // so the response can never land on top of an unconsumed instruction.
    assign imem_req_valid = (state_q == REQ) && (!ifValid_q || !stall);
    assign imem_req_addr  = fetchPc_q;
    assign reqAccepted    = imem_req_valid && imem_req_ready;
    assign slotConsumed   = ifValid_q && !stall;
    assign redirectTarget = redirect_pc & 32'hFFFF_FFFC;
    assign fetchPcInc     = fetchPc_q + 32'd4;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            fetchPc_q <= RESET_PC;
            ifValid_q <= 1'b0;
            ifPc_q    <= 32'h0000_0000;
            ifInstr_q <= NOP_INSTR;
        end else if (redirect_valid) begin
            // Any request already accepted leaves a stale response behind that
            // DRAIN must swallow; a same-cycle response is dropped right here.
            fetchPc_q <= redirectTarget;
            ifValid_q <= 1'b0;
            ifInstr_q <= NOP_INSTR;
            case (state_q)
                REQ:     state_q <= reqAccepted ? DRAIN : REQ;
                WAIT:    state_q <= imem_rsp_valid ? REQ : DRAIN;
                DRAIN:   state_q <= imem_rsp_valid ? REQ : DRAIN;
                default: state_q <= REQ;
            endcase
        end else begin
            if (slotConsumed) begin
                ifValid_q <= 1'b0;
                ifInstr_q <= NOP_INSTR;
            end
            case (state_q)
                IDLE: state_q <= REQ;
                REQ: begin
                    if (reqAccepted) begin
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        ifValid_q <= 1'b1;
                        ifInstr_q <= imem_rsp_data;
                        ifPc_q    <= fetchPc_q;
                        fetchPc_q <= fetchPcInc;
                        state_q   <= REQ;
                    end
                end
                DRAIN: begin
                    if (imem_rsp_valid) begin
                        state_q <= REQ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign if_valid = ifValid_q;
    assign if_pc    = ifPc_q;
    assign if_instr = ifInstr_q;
    assign pc_out   = fetchPc_q;

endmodule
